// File: rtl/alu_md_unit.sv
// EX-stage execution unit: one-cycle registered ALU plus an independent
// iterative multiply/divide engine that owns the HI/LO registers.
module alu_md_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       ALUctr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shift,
  output logic             out_valid,
  output logic [WIDTH-1:0] op,
  output logic             zero,
  output logic             overflow,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] md_a,
  input  logic [WIDTH-1:0] md_b,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLLV, ALU_NOR, ALU_SRAV,
    ALU_SLL, ALU_SRL, ALU_GTZ, ALU_LEZ, ALU_NE, ALU_SLT, ALU_SRLV, ALU_SLTU
  } alu_ctr_e;

  typedef enum logic {MD_IDLE, MD_RUN} md_state_e;

  // ---------------------------------------------------------------- ALU path
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic [SHW-1:0]   var_sh;
  logic             alu_ovf;

  assign sum    = A + B;
  assign diff   = A - B;
  assign var_sh = B[SHW-1:0];

  // NOTE: every variable gets a default at the top of a combinational block,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_ctr_e'(ALUctr))
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_AND:  alu_res = A & B;
      ALU_OR:   alu_res = A | B;
      ALU_XOR:  alu_res = A ^ B;
      ALU_SLLV: alu_res = A << var_sh;
      ALU_NOR:  alu_res = ~(A | B);
      ALU_SRAV: alu_res = $signed(A) >>> var_sh;
      ALU_SLL:  alu_res = A << shift;
      ALU_SRL:  alu_res = A >> shift;
      ALU_GTZ:  alu_res[0] = ~A[WIDTH-1] & (|A);
      ALU_LEZ:  alu_res[0] = A[WIDTH-1] | ~(|A);
      ALU_NE:   alu_res[0] = (A != B);
      ALU_SLT:  alu_res[0] = ($signed(A) < $signed(B));
      ALU_SRLV: alu_res = A >> var_sh;
      ALU_SLTU: alu_res[0] = (A < B);
      default:  alu_res = '0;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op        <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        op       <= alu_res;
        zero     <= (alu_res == '0);
        overflow <= alu_ovf;
      end
    end
  end

  // ------------------------------------------------------- mul/div engine
  md_state_e        state, state_nxt;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             neg_a, neg_b, is_div, b_zero;
  logic             md_accept, md_last;
  logic             is_signed;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_signed = ~md_op[0];
  assign mag_a     = (is_signed && md_a[WIDTH-1]) ? -md_a : md_a;
  assign mag_b     = (is_signed && md_b[WIDTH-1]) ? -md_b : md_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (md_start)    state_nxt = MD_RUN;
      MD_RUN:  if (cnt == '0)   state_nxt = MD_IDLE;
      default:                  state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    md_busy   = (state == MD_RUN);
    md_accept = (state == MD_IDLE) && md_start;
    md_last   = (state == MD_RUN) && (cnt == '0);
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  logic [WIDTH:0]   mul_sum, div_shl, div_dif;
  logic             div_ge;
  logic [WIDTH-1:0] hi_step, lo_step;

  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shl = {acc_hi, acc_lo[WIDTH-1]};
    div_dif = div_shl - {1'b0, opnd};
    div_ge  = ~div_dif[WIDTH];
    if (is_div) begin
      hi_step = div_ge ? div_dif[WIDTH-1:0] : div_shl[WIDTH-1:0];
      lo_step = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // With a zero divisor every step just shifts the dividend into acc_hi, so
  // the sign-fixed remainder is the original dividend without extra storage.
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, hi_fin, lo_fin;

  always_comb begin
    prod_mag = {hi_step, lo_step};
    prod_fix = (neg_a ^ neg_b) ? -prod_mag : prod_mag;
    quo_fix  = (neg_a ^ neg_b) ? -lo_step : lo_step;
    rem_fix  = neg_a ? -hi_step : hi_step;
    if (!is_div) begin
      hi_fin = prod_fix[2*WIDTH-1:WIDTH];
      lo_fin = prod_fix[WIDTH-1:0];
    end else if (b_zero) begin
      hi_fin = rem_fix;
      lo_fin = '1;
    end else begin
      hi_fin = rem_fix;
      lo_fin = quo_fix;
    end
  end

  // NOTE: the iteration registers are reset too, so a reset mid-RUN can
  // never leave a half-built operand that leaks into a later result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      is_div <= 1'b0;
      b_zero <= 1'b0;
    end else if (md_accept) begin
      cnt    <= SHW'(WIDTH-1);
      neg_a  <= is_signed & md_a[WIDTH-1];
      neg_b  <= is_signed & md_b[WIDTH-1];
      is_div <= md_op[1];
      b_zero <= (md_b == '0);
      acc_hi <= '0;
      acc_lo <= md_op[1] ? mag_a : mag_b;
      opnd   <= md_op[1] ? mag_b : mag_a;
    end else if (md_busy) begin
      acc_hi <= hi_step;
      acc_lo <= lo_step;
      if (cnt != '0) cnt <= cnt - SHW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_done <= 1'b0;
      md_div0 <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      md_done <= md_last;
      if (md_last) begin
        hi      <= hi_fin;
        lo      <= lo_fin;
        md_div0 <= is_div & b_zero;
      end
    end
  end

endmodule
